// File: rtl/gilbert_estimator.sv
// Gilbert channel parameter estimator: counts Good/Bad transitions over a window of
// accepted samples, then derives per-mille transition probabilities by serial division.
module gilbert_estimator #(
  parameter int unsigned WINDOW = 1000,
  parameter int unsigned CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic        s_state,
  output logic        s_ready,
  output logic [9:0]  p_gb_est,
  output logic [9:0]  p_bg_est,
  output logic [15:0] max_burst,
  output logic        div0_gb,
  output logic        div0_bg,
  output logic        res_valid
);

  localparam int unsigned NUM_W  = CNT_W + 10;
  localparam int unsigned STEP_W = $clog2(NUM_W);

  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(WINDOW - 1);
  localparam logic [15:0]       RUN_ONE   = 16'd1;
  localparam logic [15:0]       RUN_MAX   = 16'hFFFF;
  localparam logic [NUM_W-1:0]  K_MILLE   = NUM_W'(1000);
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_W - 1);

  typedef enum logic [1:0] {MEASURE, DIV_GB, DIV_BG, PUBLISH} state_e;

  state_e             state_q;

  logic [CNT_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   good_opp_q, good_opp_d;
  logic [CNT_W-1:0]   bad_opp_q,  bad_opp_d;
  logic [CNT_W-1:0]   gb_trans_q, gb_trans_d;
  logic [CNT_W-1:0]   bg_trans_q, bg_trans_d;
  logic               prev_state_q;
  logic               prev_valid_q;
  logic [15:0]        run_len_q,   run_len_d;
  logic [15:0]        burst_max_q, burst_max_d;

  logic [NUM_W-1:0]   num_q;
  logic [CNT_W-1:0]   den_q;
  logic [CNT_W-1:0]   rem_q;
  logic [STEP_W-1:0]  step_q;

  logic [9:0]         gb_res_q;
  logic               gb_zero_q;
  logic [9:0]         bg_res_q;
  logic               bg_zero_q;

  logic [9:0]         p_gb_q;
  logic [9:0]         p_bg_q;
  logic [15:0]        max_burst_q;
  logic               div0_gb_q;
  logic               div0_bg_q;
  logic               res_valid_q;

  logic               accept;
  logic               win_last;

  logic [CNT_W:0]     rem_sh;
  logic               fits;
  logic [CNT_W-1:0]   rem_next;
  logic [NUM_W-1:0]   num_step;
  logic               den_zero;
  logic               last_step;
  logic [NUM_W-1:0]   quot_full;
  logic [9:0]         quot_sat;

  assign s_ready  = (state_q == MEASURE);
  assign accept   = s_valid && s_ready;
  assign win_last = accept && (win_cnt_q == WIN_LAST);

  always_comb begin
    good_opp_d  = good_opp_q;
    bad_opp_d   = bad_opp_q;
    gb_trans_d  = gb_trans_q;
    bg_trans_d  = bg_trans_q;
    run_len_d   = run_len_q;
    burst_max_d = burst_max_q;
    if (accept) begin
      if (prev_valid_q) begin
        if (prev_state_q) begin
          good_opp_d = good_opp_q + CNT_ONE;
          if (!s_state) gb_trans_d = gb_trans_q + CNT_ONE;
        end else begin
          bad_opp_d = bad_opp_q + CNT_ONE;
          if (s_state) bg_trans_d = bg_trans_q + CNT_ONE;
        end
      end
      if (s_state) begin
        run_len_d = '0;
      end else if (run_len_q != RUN_MAX) begin
        run_len_d = run_len_q + RUN_ONE;
      end
      // Compared against the updated run so a burst still open at window end is counted.
      burst_max_d = (run_len_d > burst_max_q) ? run_len_d : burst_max_q;
    end
  end

  // One restoring-division step; the low CNT_W bits of the difference are exact since rem < den.
  always_comb begin
    rem_sh    = {rem_q, num_q[NUM_W-1]};
    fits      = (rem_sh >= {1'b0, den_q});
    rem_next  = fits ? (rem_sh[CNT_W-1:0] - den_q) : rem_sh[CNT_W-1:0];
    num_step  = {num_q[NUM_W-2:0], fits};
    den_zero  = (den_q == '0);
    last_step = (step_q == LAST_STEP);
    quot_full = den_zero ? '0 : num_step;
    quot_sat  = (quot_full >= K_MILLE) ? 10'd999 : quot_full[9:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_cnt_q    <= '0;
      good_opp_q   <= '0;
      bad_opp_q    <= '0;
      gb_trans_q   <= '0;
      bg_trans_q   <= '0;
      prev_state_q <= 1'b0;
      prev_valid_q <= 1'b0;
      run_len_q    <= '0;
      burst_max_q  <= '0;
    end else begin
      if (win_last) begin
        win_cnt_q <= '0;
      end else if (accept) begin
        win_cnt_q <= win_cnt_q + CNT_ONE;
      end
      if (accept) begin
        prev_state_q <= s_state;
        prev_valid_q <= 1'b1;
      end
      run_len_q <= run_len_d;
      if (state_q == PUBLISH) begin
        good_opp_q  <= '0;
        bad_opp_q   <= '0;
        gb_trans_q  <= '0;
        bg_trans_q  <= '0;
        burst_max_q <= '0;
      end else begin
        good_opp_q  <= good_opp_d;
        bad_opp_q   <= bad_opp_d;
        gb_trans_q  <= gb_trans_d;
        bg_trans_q  <= bg_trans_d;
        burst_max_q <= burst_max_d;
      end
    end
  end

  // A zero denominator still walks every step so the result latency never varies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= MEASURE;
      num_q       <= '0;
      den_q       <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      gb_res_q    <= '0;
      gb_zero_q   <= 1'b0;
      bg_res_q    <= '0;
      bg_zero_q   <= 1'b0;
      p_gb_q      <= '0;
      p_bg_q      <= '0;
      max_burst_q <= '0;
      div0_gb_q   <= 1'b0;
      div0_bg_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        MEASURE: begin
          if (win_last) begin
            num_q   <= NUM_W'(gb_trans_d) * K_MILLE;
            den_q   <= good_opp_d;
            rem_q   <= '0;
            step_q  <= '0;
            state_q <= DIV_GB;
          end
        end
        DIV_GB: begin
          if (!den_zero) begin
            num_q <= num_step;
            rem_q <= rem_next;
          end
          step_q <= step_q + STEP_ONE;
          if (last_step) begin
            gb_res_q  <= quot_sat;
            gb_zero_q <= den_zero;
            num_q     <= NUM_W'(bg_trans_q) * K_MILLE;
            den_q     <= bad_opp_q;
            rem_q     <= '0;
            step_q    <= '0;
            state_q   <= DIV_BG;
          end
        end
        DIV_BG: begin
          if (!den_zero) begin
            num_q <= num_step;
            rem_q <= rem_next;
          end
          step_q <= step_q + STEP_ONE;
          if (last_step) begin
            bg_res_q  <= quot_sat;
            bg_zero_q <= den_zero;
            step_q    <= '0;
            state_q   <= PUBLISH;
          end
        end
        PUBLISH: begin
          p_gb_q      <= gb_res_q;
          p_bg_q      <= bg_res_q;
          div0_gb_q   <= gb_zero_q;
          div0_bg_q   <= bg_zero_q;
          max_burst_q <= burst_max_q;
          res_valid_q <= 1'b1;
          state_q     <= MEASURE;
        end
        default: state_q <= MEASURE;
      endcase
    end
  end

  assign p_gb_est  = p_gb_q;
  assign p_bg_est  = p_bg_q;
  assign max_burst = max_burst_q;
  assign div0_gb   = div0_gb_q;
  assign div0_bg   = div0_bg_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_gilbert_estimator.sv
// Directed bench for gilbert_estimator: a WINDOW=8 instance for pattern tests and a
// WINDOW=1000 instance for the all-Good case, checked against a scoreboard model.
module tb_gilbert_estimator;

  localparam int LATENCY = 53;

  typedef struct {
    int gb;
    int bg;
    int burst;
    int d0gb;
    int d0bg;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetN;
  logic        sValid[2];
  logic        sState[2];
  logic        sReady[2];
  logic [9:0]  pGb[2];
  logic [9:0]  pBg[2];
  logic [15:0] maxBurst[2];
  logic        div0Gb[2];
  logic        div0Bg[2];
  logic        resValid[2];

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  int windowLen[2];
  int winCnt[2];
  int goodOpp[2];
  int badOpp[2];
  int gbT[2];
  int bgT[2];
  int runLen[2];
  int burstMax[2];
  bit prevValid[2];
  bit prevState[2];
  int lastAccept[2];
  exp_t expQ[$];

  int   acc;
  int   lowCnt;
  int   guard;
  bit   sawPulse;
  bit   gotAcc;
  exp_t e;

  gilbert_estimator #(.WINDOW(8)) dutA (
    .clk(clk), .reset(resetN), .s_valid(sValid[0]), .s_state(sState[0]),
    .s_ready(sReady[0]), .p_gb_est(pGb[0]), .p_bg_est(pBg[0]),
    .max_burst(maxBurst[0]), .div0_gb(div0Gb[0]), .div0_bg(div0Bg[0]),
    .res_valid(resValid[0])
  );

  gilbert_estimator #(.WINDOW(1000)) dutB (
    .clk(clk), .reset(resetN), .s_valid(sValid[1]), .s_state(sState[1]),
    .s_ready(sReady[1]), .p_gb_est(pGb[1]), .p_bg_est(pBg[1]),
    .max_burst(maxBurst[1]), .div0_gb(div0Gb[1]), .div0_bg(div0Bg[1]),
    .res_valid(resValid[1])
  );

  // Free-running clock plus a cycle counter used to measure result latency.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expd);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      winCnt[s] = 0; goodOpp[s] = 0; badOpp[s] = 0; gbT[s] = 0; bgT[s] = 0;
      runLen[s] = 0; burstMax[s] = 0; prevValid[s] = 0; prevState[s] = 0;
    end
    expQ.delete();
  endtask

  // Reference behaviour of one accepted sample; pushes the expected result at window end.
  task automatic modelAccept(input int sel, input bit st);
    exp_t x;
    if (prevValid[sel]) begin
      if (prevState[sel]) begin
        goodOpp[sel]++;
        if (!st) gbT[sel]++;
      end else begin
        badOpp[sel]++;
        if (st) bgT[sel]++;
      end
    end
    prevValid[sel] = 1;
    prevState[sel] = st;
    if (st) runLen[sel] = 0;
    else if (runLen[sel] < 65535) runLen[sel]++;
    if (runLen[sel] > burstMax[sel]) burstMax[sel] = runLen[sel];
    winCnt[sel]++;
    if (winCnt[sel] == windowLen[sel]) begin
      x.d0gb  = (goodOpp[sel] == 0) ? 1 : 0;
      x.d0bg  = (badOpp[sel] == 0) ? 1 : 0;
      x.gb    = (goodOpp[sel] == 0) ? 0 : (gbT[sel] * 1000) / goodOpp[sel];
      x.bg    = (badOpp[sel] == 0) ? 0 : (bgT[sel] * 1000) / badOpp[sel];
      if (x.gb > 999) x.gb = 999;
      if (x.bg > 999) x.bg = 999;
      x.burst = burstMax[sel];
      expQ.push_back(x);
      winCnt[sel] = 0; goodOpp[sel] = 0; badOpp[sel] = 0;
      gbT[sel] = 0; bgT[sel] = 0; burstMax[sel] = 0;
    end
  endtask

  // Drive one sample with s_valid high for a single cycle once the DUT is ready.
  task automatic applyStimulus(input int sel, input bit st);
    int g = 0;
    while (!sReady[sel] && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("ready_wait", sReady[sel], 1);
    sValid[sel] = 1'b1;
    sState[sel] = st;
    @(posedge clk); #1;
    modelAccept(sel, st);
    lastAccept[sel] = cycle;
    sValid[sel] = 1'b0;
  endtask

  // Eight samples, MSB first, 1 = Good.
  task automatic sendPattern(input int sel, input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) applyStimulus(sel, pat[i]);
  endtask

  // Hold s_valid high for one cycle regardless of s_ready; only accepted samples reach the model.
  task automatic streamCycle(input int sel, input bit st, output bit accepted);
    accepted = sReady[sel];
    sValid[sel] = 1'b1;
    sState[sel] = st;
    @(posedge clk); #1;
    if (accepted) begin
      modelAccept(sel, st);
      lastAccept[sel] = cycle;
    end
  endtask

  task automatic compareResult(input int sel, output exp_t x);
    check("scoreboard_nonempty", (expQ.size() != 0), 1);
    x = '{gb: 0, bg: 0, burst: 0, d0gb: 0, d0bg: 0};
    if (expQ.size() != 0) begin
      x = expQ.pop_front();
      check("p_gb_est", pGb[sel], x.gb);
      check("p_bg_est", pBg[sel], x.bg);
      check("max_burst", maxBurst[sel], x.burst);
      check("div0_gb", div0Gb[sel], x.d0gb);
      check("div0_bg", div0Bg[sel], x.d0bg);
    end
  endtask

  // Wait for the result pulse, check latency and values, then confirm the pulse ends and values hold.
  task automatic checkOutput(input int sel);
    int   g = 0;
    exp_t x;
    while (!resValid[sel] && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    check("res_valid_seen", resValid[sel], 1);
    if (resValid[sel]) begin
      check("latency", cycle - lastAccept[sel], LATENCY);
      compareResult(sel, x);
      @(posedge clk); #1;
      check("res_valid_pulse", resValid[sel], 0);
      check("hold_p_gb", pGb[sel], x.gb);
      check("hold_p_bg", pBg[sel], x.bg);
      check("hold_burst", maxBurst[sel], x.burst);
    end
  endtask

  task automatic checkReset(input int sel);
    check("rst_s_ready", sReady[sel], 1);
    check("rst_p_gb", pGb[sel], 0);
    check("rst_p_bg", pBg[sel], 0);
    check("rst_max_burst", maxBurst[sel], 0);
    check("rst_div0_gb", div0Gb[sel], 0);
    check("rst_div0_bg", div0Bg[sel], 0);
    check("rst_res_valid", resValid[sel], 0);
  endtask

  task automatic doReset();
    resetN = 1'b0;
    @(posedge clk); #1;
    resetN = 1'b1;
    modelReset();
  endtask

  initial begin
    windowLen[0] = 8;
    windowLen[1] = 1000;
    for (int s = 0; s < 2; s++) begin
      sValid[s] = 1'b0;
      sState[s] = 1'b1;
      lastAccept[s] = 0;
    end
    modelReset();
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset(0);
    checkReset(1);
    resetN = 1'b1;

    $display("[TB] alternating G,B pattern, saturating estimates");
    sendPattern(0, 8'b1010_1010);
    checkOutput(0);

    $display("[TB] G,G,G,G,B,B,B,G after reset");
    doReset();
    sendPattern(0, 8'b1111_0001);
    checkOutput(0);

    $display("[TB] all-Bad window after a window ending in Bad");
    sendPattern(0, 8'b1111_1000);
    checkOutput(0);
    sendPattern(0, 8'b0000_0000);
    checkOutput(0);

    $display("[TB] s_valid held high through window and division");
    acc = 0;
    guard = 0;
    while (acc < 8 && guard < 100) begin
      streamCycle(0, (8'b0110_1001 >> (7 - acc)) & 1'b1, gotAcc);
      if (gotAcc) acc++;
      guard++;
    end
    lowCnt = 0;
    while (!sReady[0] && lowCnt < 200) begin
      lowCnt++;
      streamCycle(0, lowCnt[0], gotAcc);
    end
    check("s_ready_low_cycles", lowCnt, LATENCY);
    check("res_valid_on_ready", resValid[0], 1);
    compareResult(0, e);
    acc = 0;
    guard = 0;
    while (acc < 8 && guard < 100) begin
      streamCycle(0, (8'b1100_1010 >> (7 - acc)) & 1'b1, gotAcc);
      if (gotAcc) acc++;
      guard++;
    end
    sValid[0] = 1'b0;
    checkOutput(0);

    $display("[TB] reset during Bad->Good division");
    sendPattern(0, 8'b1001_1011);
    repeat (35) @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    checkReset(0);
    modelReset();
    sawPulse = 0;
    @(posedge clk); #1;
    resetN = 1'b1;
    repeat (60) begin
      @(posedge clk); #1;
      if (resValid[0]) sawPulse = 1;
    end
    check("no_res_valid_after_abort", sawPulse, 0);
    sendPattern(0, 8'b0110_0111);
    checkOutput(0);

    $display("[TB] WINDOW=1000, all Good after reset");
    for (int i = 0; i < 1000; i++) applyStimulus(1, 1'b1);
    checkOutput(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
